// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter (double-dabble, 17 cycles per conversion).
// Optional BIN2BCD_OVF_DASH_EN: overflow shows 16'hAAAA instead of saturating to BCD(SAT_VAL).
module bin2bcd_seq #(
  parameter int unsigned SAT_VAL = 9999
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [15:0] bcd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  localparam logic [15:0] SAT16 = 16'(SAT_VAL);
`ifdef BIN2BCD_OVF_DASH_EN
  localparam logic [15:0] OVF_PAT = 16'hAAAA;
`else
  localparam logic [15:0] OVF_PAT = to_bcd(SAT_VAL);
`endif

  state_t      state;
  logic [15:0] binreg;
  logic [15:0] scratch;
  logic [4:0]  cnt;
  logic        ovf_next;
  logic [15:0] adj;

  // add-3 correction, 4-bit modular per digit
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      binreg   <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      bcd      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            binreg   <= bin;
            scratch  <= '0;
            cnt      <= '0;
            ovf_next <= (bin > SAT16);
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // bit shifted out of adj[15] is dropped; only overflow operands reach it
          scratch <= {adj[14:0], binreg[15]};
          binreg  <= {binreg[14:0], 1'b0};
          cnt     <= cnt + 5'd1;
          if (cnt == 5'd15)
            state <= DONE;
        end
        DONE: begin
          bcd   <= ovf_next ? OVF_PAT : scratch;
          ovf   <= ovf_next;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a cycle model predicts accepts, busy and done;
// expected {ovf,bcd} are queued at each accepted start and popped on done.
module tb_bin2bcd_seq;
  localparam int unsigned SAT = 9999;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bin = '0;
  logic        busy, done, ovf;
  logic [15:0] bcd;

  int n_checks = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_done = 0;
  int mcnt = 0;
  logic mdone = 1'b0;
  logic [16:0] exp_q[$];
  logic [16:0] last_res = '0;

  bin2bcd_seq #(.SAT_VAL(SAT)) dut (
    .clk(clk), .clr(clr), .start(start), .bin(bin),
    .busy(busy), .done(done), .ovf(ovf), .bcd(bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] ref_res(input logic [15:0] v);
    int unsigned x;
    x = v;
    if (x > SAT) begin
`ifdef BIN2BCD_OVF_DASH_EN
      return {1'b1, 16'hAAAA};
`else
      return {1'b1, 4'((SAT / 1000) % 10), 4'((SAT / 100) % 10), 4'((SAT / 10) % 10), 4'(SAT % 10)};
`endif
    end
    return {1'b0, 4'((x / 1000) % 10), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  // cycle model plus output checks, sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    mdone = 1'b0;
    if (clr) begin
      mcnt = 0;
    end else if (mcnt == 0) begin
      if (start) begin
        mcnt = 17;
        exp_q.push_back(ref_res(bin));
        n_acc++;
      end
    end else begin
      if (mcnt == 1) mdone = 1'b1;
      mcnt--;
    end
    #1;
    chk("busy", 32'(busy), 32'(mcnt != 0));
    chk("done", 32'(done), 32'(mdone));
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'(exp_q.size()), 32'd1);
      end else begin
        last_res = exp_q.pop_front();
        chk("bcd", 32'(bcd), 32'(last_res[15:0]));
        chk("ovf", 32'(ovf), 32'(last_res[16]));
      end
    end
  end

  always @(posedge clr) begin
    mcnt = 0;
    mdone = 1'b0;
    n_acc -= exp_q.size();
    exp_q.delete();
  end

  task automatic do_start(input logic [15:0] v);
    @(negedge clk);
    start = 1'b1;
    bin = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && mcnt != 0; i++) @(negedge clk);
    chk("idle_timeout", 32'(mcnt), 32'd0);
  endtask

  initial begin
    int d0;
    logic [15:0] v;
    repeat (3) @(negedge clk);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // start presented on the very edge that first sees clr low
    clr = 1'b0;
    start = 1'b1;
    bin = 16'd1234;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("bcd_1234", 32'(bcd), 32'h1234);

    // back-to-back: second start lands on edge N+18
    do_start(16'd0);
    repeat (16) @(negedge clk);
    do_start(16'd9999);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_bcd", 32'(bcd), 32'h9999);
    chk("hold_ovf", 32'(ovf), 32'h0);

    do_start(16'd10000);
    wait_idle();
    do_start(16'hFFFF);
    wait_idle();
    do_start(16'd9999);
    wait_idle();

    // start held high: accepts only at N and N+18 within a 36-cycle window
    d0 = n_done;
    @(negedge clk);
    start = 1'b1;
    bin = 16'd42;
    repeat (36) @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("held_conversions", 32'(n_done - d0), 32'd2);

    // start while busy with a different operand is ignored
    do_start(16'd321);
    repeat (3) @(negedge clk);
    start = 1'b1;
    bin = 16'd888;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("busy_ignored_bcd", 32'(bcd), 32'h0321);

    // abort mid-shift
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    d0 = n_done;
    do_start(16'd5678);
    repeat (8) @(posedge clk);
    #2 clr = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_bcd", 32'(bcd), 32'h0);
    repeat (25) @(negedge clk);
    chk("abort_no_done", 32'(n_done - d0), 32'd0);
    chk("abort_bcd_later", 32'(bcd), 32'h0);
    clr = 1'b0;
    do_start(16'd77);
    wait_idle();
    chk("after_abort", 32'(bcd), 32'h0077);

    for (int k = 0; k < 1000; k++) begin
      v = (k % 2 == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom_range(0, 65535));
      do_start(v);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_per_accept", 32'(n_done), 32'(n_acc));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

endmodule
